// File: rtl/mac_array_ctrl_if.sv
// Command, SRAM-read, instruction and status bundle between the core and the MAC array sequencer.
interface mac_array_ctrl_if #(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned len_bw = 8
);
  logic                start;
  logic [len_bw-1:0]   kern_len;
  logic [len_bw-1:0]   exec_len;
  logic [col-1:0]      valid_in;
  logic                mem_rd;
  logic [len_bw:0]     mem_addr;
  logic [2*row-1:0]    inst_w;
  logic                ofifo_wr;
  logic                busy;
  logic                done;
  logic                err;

  // Sequencer side
  modport slave (
    input  start, kern_len, exec_len, valid_in,
    output mem_rd, mem_addr, inst_w, ofifo_wr, busy, done, err
  );

  // Core / environment side
  modport master (
    output start, kern_len, exec_len, valid_in,
    input  mem_rd, mem_addr, inst_w, ofifo_wr, busy, done, err
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Sequencer for the systolic MAC array: kernel load, gap, execute, drain with timeout.
module mac_array_ctrl #(
  parameter int unsigned row       = 8,
  parameter int unsigned col       = 8,
  parameter int unsigned len_bw    = 8,
  parameter int unsigned gap       = 8,
  parameter int unsigned drain_max = 64
) (
  input  logic             clk,
  input  logic             reset,
  mac_array_ctrl_if.slave  bus
);

  localparam int unsigned VC_W   = len_bw + 1;
  localparam int unsigned GAP_W  = $clog2(gap + 1);
  localparam int unsigned DRN_W  = $clog2(drain_max + 1);
  localparam int unsigned CNT_W0 = (GAP_W > DRN_W) ? GAP_W : DRN_W;
  localparam int unsigned CNT_W  = (CNT_W0 > len_bw) ? CNT_W0 : len_bw;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [len_bw-1:0]     r_k;
  logic [len_bw-1:0]     r_e;
  logic [VC_W-1:0]       r_vcnt;
  logic [VC_W-1:0]       w_vcnt_nxt;
  logic [VC_W-1:0]       r_addr;
  logic                  r_mem_rd;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  w_timeout;
  logic                  w_valid;
  logic                  w_accept;
  logic [row-1:0][1:0]   r_inst;
  logic                  w_unused_valid;

  // Only the last column's valid is counted; the rest of the bus is observed but unused
  assign w_valid        = bus.valid_in[col-1];
  assign w_unused_valid = ^bus.valid_in;
  assign w_accept       = (r_state == S_IDLE) && bus.start;
  assign w_cnt_inc      = r_cnt + CNT_W'(1);

  // Saturating count of bottom-row valid pulses seen while busy
  always_comb begin
    w_vcnt_nxt = r_vcnt;
    if (w_valid && r_busy && (r_vcnt != '1)) begin
      w_vcnt_nxt = r_vcnt + VC_W'(1);
    end
  end

  // Next-state decode; completion is checked before timeout so a last-cycle pulse wins
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.kern_len != '0)      w_state_nxt = S_LOAD;
          else if (bus.exec_len != '0) w_state_nxt = S_GAP;
          else                         w_state_nxt = S_DONE;
        end
      end
      S_LOAD: begin
        if (w_cnt_inc == CNT_W'(r_k)) w_state_nxt = (r_e != '0) ? S_GAP : S_DRAIN;
      end
      S_GAP: begin
        if (w_cnt_inc == CNT_W'(gap)) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_cnt_inc == CNT_W'(r_e)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_vcnt_nxt >= VC_W'(r_e)) begin
          w_state_nxt = S_DONE;
        end else if (w_cnt_inc == CNT_W'(drain_max)) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, per-state cycle counter and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mem_rd <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? '0 : w_cnt_inc;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
      r_err    <= (w_state_nxt == S_DONE) && w_timeout;
      r_mem_rd <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_EXEC);
    end
  end

  // Command latch, SRAM address walk and valid counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k    <= '0;
      r_e    <= '0;
      r_addr <= '0;
      r_vcnt <= '0;
    end else if (w_accept) begin
      r_k    <= bus.kern_len;
      r_e    <= bus.exec_len;
      r_addr <= '0;
      r_vcnt <= '0;
    end else begin
      r_vcnt <= w_vcnt_nxt;
      if (r_mem_rd) r_addr <= r_addr + VC_W'(1);
    end
  end

  // Instruction pipe: row 0 tags the SRAM data returning from last cycle's read, row r lags r more
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inst <= '0;
    end else begin
      r_inst[0] <= {(r_state == S_EXEC) && r_mem_rd, (r_state == S_LOAD) && r_mem_rd};
      for (int i = 1; i < int'(row); i++) begin
        r_inst[i] <= r_inst[i-1];
      end
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_addr;
  assign bus.inst_w   = r_inst;
  assign bus.ofifo_wr = w_valid & r_busy;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the systolic MAC array built from `mac_row` instances. It accepts a start command, then issues input-SRAM reads for kernel weights and activations. It drives the per-row 2-bit instruction bus, row-staggered one cycle per row. It counts returning `valid` pulses from the bottom row to decide completion, and reports `busy`/`done`/`err` to the top-level core.

## Interface
- `row`, default 8: number of `mac_row` instances stacked north-south.
- `col`, default 8: columns per row (width of `valid_in`).
- `len_bw`, default 8: width of `kern_len` / `exec_len`.
- `gap`, default 8: idle cycles between kernel load and execute (≥1).
- `drain_max`, default 64: DRAIN timeout in cycles (≥1).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset==0` at a rising edge resets all state.
- `start`  in  1  command request; sampled only in IDLE.
- `kern_len`  in  len_bw  weight vectors to load; sampled with `start`.
- `exec_len`  in  len_bw  activation vectors to execute; sampled with `start`.
- `valid_in`  in  col  valid bus from the bottom `mac_row`; bit col-1 is counted.
- `mem_rd`  out  1  input-SRAM read enable; data returns one cycle later.
- `mem_addr`  out  len_bw+1  input-SRAM read address.
- `inst_w`  out  2*row  per-row instruction; row r at bits [2r+1:2r]. Bit 1 = execute, bit 0 = kernel load.
- `ofifo_wr`  out  1  = `valid_in[col-1] & busy`; this output is combinational.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, high while in DONE.
- `err`  out  1  high in DONE when DRAIN timed out; low otherwise.

## Operation
- FSM states: IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
- IDLE:
  - `start=1`: latch K=`kern_len` and E=`exec_len`, clear `mem_addr`, the valid counter and the timeout flag.
  - Next state: LOAD if K>0, else GAP if E>0, else DONE.
  - `start` is ignored in every other state.
- LOAD, K cycles:
  - `mem_rd=1`; `mem_addr` runs 0..K-1, incrementing after each read.
  - After K cycles go to GAP if E>0, else DRAIN.
- GAP, `gap` cycles: `mem_rd=0`, then go to EXEC.
- EXEC, E cycles:
  - `mem_rd=1`; addresses K..K+E-1, continuing from LOAD.
  - After E cycles go to DRAIN.
- DRAIN:
  - Exit to DONE with `err=0` when the valid count reaches E.
  - Exit to DONE with `err=1` after `drain_max` cycles in DRAIN.
  - E==0 exits after one cycle with `err=0`.
- DONE: lasts one cycle (`done=1`, `busy=1`), then IDLE.
- Valid counter:
  - Width len_bw+1.
  - Increments on every cycle with `valid_in[col-1]=1` while `busy` (any state, including EXEC).
  - Saturates at all-ones.
- Instruction generation:
  - `inst0` is a registered copy of the phase of the previous cycle: 01 if the previous cycle was LOAD with `mem_rd`, 10 if it was EXEC with `mem_rd`, else 00.
  - This aligns each instruction with the SRAM data it accompanies.
  - `inst_w` row r = `inst0` delayed r further cycles through a shift register (row 0 = `inst0`).
  - Never 11.

## Timing
- Reset: state IDLE; `mem_rd`, `mem_addr`, `inst_w` (all rows, all shift stages), `busy`, `done`, `err` = 0; counters 0.
- Cycle 0 = edge sampling `start`. LOAD occupies cycles 1..K, GAP K+1..K+gap, EXEC K+gap+1..K+gap+E.
- Row-0 instruction lags `mem_rd` by 1 cycle; row r lags by 1+r cycles.
- After leaving EXEC, the shift register keeps flushing its last instructions (≤row cycles) through DRAIN/DONE/IDLE; it is not cleared early.
- Reset low mid-operation: all outputs take reset values at that edge, including in-flight shift stages.
- `valid_in` pulse in the same cycle DRAIN reaches its count: count first, so completion takes priority over timeout in that cycle.
- `start` high in DONE is ignored; a new `start` is accepted the cycle after DONE (IDLE).

## Test plan
- Nominal: row=8, gap=8, K=8, E=4, bench returns 4 `valid_in[7]` pulses at cycles 26..29.
  - `mem_rd` high at cycles 1–8 (addr 0–7) and 17–20 (addr 8–11).
  - Row-0 inst=01 at cycles 2–9 and 10 at 18–21; row-7 inst=10 at 25–28.
  - `done` pulses in cycle 30 with `err=0`; IDLE at cycle 31.
- Timeout: K=8, E=4, only 3 valid pulses returned → DRAIN lasts 64 cycles, then `done=1` with `err=1`.
- Degenerate: K=0, E=0 → state DONE at cycle 1, `mem_rd` never asserted, `inst_w` stays 0.
- Reset mid-EXEC: drive `reset=0` at cycle 18 → next cycle all outputs 0, `busy=0`. A later `start` restarts from `mem_addr=0`.
- Command blocking: `start` pulsed during LOAD and during DONE with different lengths → ignored. Only the lengths latched at cycle 0 govern the run; `start` in the following IDLE cycle is accepted.
